// File: rtl/config_tp_onchip_ram_dp_if.sv
// rtl/config_tp_onchip_ram_dp_if.sv - Avalon-MM slave port bundle for the dual-port RAM
//
// One instance carries everything for a single RAM port:
//   address        word address
//   chipselect     port select
//   read / write   access requests (write wins if both are set)
//   byteenable     per-byte write enable
//   writedata      write data
//   readdata       read data, held while readdatavalid is low
//   readdatavalid  read data qualifier
//   waitrequest    stall, high while the clear engine owns the array
//
// Modports:
//   master  drives the request side (CPU, DMA, testbench)
//   slave   the RAM side

interface config_tp_onchip_ram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);

    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address,
        output chipselect,
        output read,
        output write,
        output byteenable,
        output writedata,
        input  readdata,
        input  readdatavalid,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read,
        input  write,
        input  byteenable,
        input  writedata,
        output readdata,
        output readdatavalid,
        output waitrequest
    );

endinterface

// File: rtl/config_tp_onchip_ram_dp.sv
// rtl/config_tp_onchip_ram_dp.sv - parametrised true dual-port RAM with collision handling and clear engine
//
// Ports:
//   clk         single system clock, rising edge
//   reset       asynchronous, active-high
//   s1, s2      Avalon-MM slave ports (config_tp_onchip_ram_dp_if.slave); s1 is port A, s2 is port B
//   clear_req   single-cycle request to zero the whole array
//   clear_busy  clear sweep in progress
//   collision   one-cycle pulse after both ports wrote the same word; port B's write was dropped
//
// Parameters:
//   DATA_WIDTH      word width, multiple of 8
//   ADDR_WIDTH      word-address width
//   DEPTH           number of words, DEPTH <= 2**ADDR_WIDTH
//   READ_LATENCY    1 or 2 cycles from acceptance to readdatavalid
//   CLEAR_ON_RESET  nonzero: sweep the array to zero after every reset release

module config_tp_onchip_ram_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 13,
    parameter int DEPTH          = 8192,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    config_tp_onchip_ram_dp_if.slave   s1,
    config_tp_onchip_ram_dp_if.slave   s2,
    input  logic                       clear_req,
    output logic                       clear_busy,
    output logic                       collision
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_PTR = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             busy;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                // clear_req is deliberately not looked at here: a request
                // during a sweep is absorbed by the sweep already running.
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Straight decode of the state register, so waitrequest rises the
    // cycle after clear_req and falls the cycle after the last word.
    assign busy           = (state_q == ST_CLEAR);
    assign clear_busy     = busy;
    assign s1.waitrequest = busy;
    assign s2.waitrequest = busy;

    // ------------------------------------------------------------------
    // Access decode (a = s1, b = s2)
    // ------------------------------------------------------------------
    logic             a_acc;
    logic             a_wr;
    logic             a_rd;
    logic             a_in;
    logic [IDX_W-1:0] a_idx;
    logic             b_acc;
    logic             b_wr;
    logic             b_rd;
    logic             b_in;
    logic [IDX_W-1:0] b_idx;
    logic             same_addr;
    logic             b_drop;
    logic             a_commit;
    logic             b_commit;
    logic             clr_commit;

    assign a_acc = s1.chipselect & (s1.read | s1.write) & ~busy & ~reset;
    assign a_wr  = a_acc & s1.write;
    assign a_rd  = a_acc & s1.read & ~s1.write;
    assign a_in  = ({1'b0, s1.address} < DEPTH_A);
    assign a_idx = s1.address[IDX_W-1:0];

    assign b_acc = s2.chipselect & (s2.read | s2.write) & ~busy & ~reset;
    assign b_wr  = b_acc & s2.write;
    assign b_rd  = b_acc & s2.read & ~s2.write;
    assign b_in  = ({1'b0, s2.address} < DEPTH_A);
    assign b_idx = s2.address[IDX_W-1:0];

    // Out-of-range double writes touch nothing, so they are not collisions.
    assign same_addr  = (s1.address == s2.address);
    assign b_drop     = a_wr & b_wr & same_addr & a_in;
    assign a_commit   = a_wr & a_in;
    assign b_commit   = b_wr & b_in & ~b_drop;
    assign clr_commit = busy & ~reset;

    // ------------------------------------------------------------------
    // Storage. Never reset: contents are only ever cleared by the sweep.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_commit) begin
            mem[ptr_q] <= '0;
        end
        if (b_commit) begin
            for (int i = 0; i < BYTES; i++) begin
                if (s2.byteenable[i]) begin
                    mem[b_idx][8*i +: 8] <= s2.writedata[8*i +: 8];
                end
            end
        end
        // Port A last, so it wins any overlap with port B.
        if (a_commit) begin
            for (int i = 0; i < BYTES; i++) begin
                if (s1.byteenable[i]) begin
                    mem[a_idx][8*i +: 8] <= s1.writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
        end else begin
            collision <= b_drop;
        end
    end

    // ------------------------------------------------------------------
    // Read pipelines. The first stage samples the array before this
    // cycle's writes land, which gives read-old-data on both ports.
    // ------------------------------------------------------------------
    logic [1:0]            rd_acc;
    logic [DATA_WIDTH-1:0] rd_raw  [2];
    logic [1:0]            rd_vout;
    logic [DATA_WIDTH-1:0] rd_dout [2];

    assign rd_acc[0] = a_rd;
    assign rd_acc[1] = b_rd;
    assign rd_raw[0] = a_in ? mem[a_idx] : '0;
    assign rd_raw[1] = b_in ? mem[b_idx] : '0;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic                  v1_q;
        logic [DATA_WIDTH-1:0] d1_q;

        // Data registers only load with a valid entry, so readdata holds
        // the last returned word between reads.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v1_q <= 1'b0;
                d1_q <= '0;
            end else begin
                v1_q <= rd_acc[p];
                if (rd_acc[p]) begin
                    d1_q <= rd_raw[p];
                end
            end
        end

        if (READ_LATENCY >= 2) begin : g_lat2
            logic                  v2_q;
            logic [DATA_WIDTH-1:0] d2_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        d2_q <= d1_q;
                    end
                end
            end

            assign rd_vout[p] = v2_q;
            assign rd_dout[p] = d2_q;
        end else begin : g_lat1
            assign rd_vout[p] = v1_q;
            assign rd_dout[p] = d1_q;
        end
    end

    assign s1.readdatavalid = rd_vout[0];
    assign s1.readdata      = rd_dout[0];
    assign s2.readdatavalid = rd_vout[1];
    assign s2.readdata      = rd_dout[1];

endmodule

// File: tb/tb_config_tp_onchip_ram_dp.sv
// tb/tb_config_tp_onchip_ram_dp.sv - scoreboard bench over three RAM configurations sharing one stimulus stream

module tb_config_tp_onchip_ram_dp;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;

    logic [3:0]  s1_address, s2_address;
    logic        s1_chipselect, s2_chipselect;
    logic        s1_read, s2_read, s1_write, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;

    logic [2:0]  busy, col, wt1, wt2;
    logic [5:0]  rv;
    logic [31:0] rd [6];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [3][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    config_tp_onchip_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) p1 [3] ();
    config_tp_onchip_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) p2 [3] ();

    // dut 0: DEPTH 16, latency 1; dut 1: DEPTH 16, latency 2; dut 2: DEPTH 12, latency 1
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 2) ? 12 : 16;
        localparam int L = (g == 1) ? 2 : 1;

        assign p1[g].address    = s1_address;
        assign p1[g].chipselect = s1_chipselect;
        assign p1[g].read       = s1_read;
        assign p1[g].write      = s1_write;
        assign p1[g].byteenable = s1_byteenable;
        assign p1[g].writedata  = s1_writedata;
        assign p2[g].address    = s2_address;
        assign p2[g].chipselect = s2_chipselect;
        assign p2[g].read       = s2_read;
        assign p2[g].write      = s2_write;
        assign p2[g].byteenable = s2_byteenable;
        assign p2[g].writedata  = s2_writedata;

        assign rv[2*g]   = p1[g].readdatavalid;
        assign rv[2*g+1] = p2[g].readdatavalid;
        assign rd[2*g]   = p1[g].readdata;
        assign rd[2*g+1] = p2[g].readdata;
        assign wt1[g]    = p1[g].waitrequest;
        assign wt2[g]    = p2[g].waitrequest;

        config_tp_onchip_ram_dp #(
            .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(D),
            .READ_LATENCY(L), .CLEAR_ON_RESET(1)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .s1         (p1[g]),
            .s2         (p2[g]),
            .clear_req  (clear_req),
            .clear_busy (busy[g]),
            .collision  (col[g])
        );
    end

    function automatic int dep(input int d);
        return (d == 2) ? 12 : 16;
    endfunction

    function automatic int lat(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] rdm(input int d, input logic [3:0] a);
        return (int'(a) < dep(d)) ? mdl[d][a] : 32'h0;
    endfunction

    task automatic wrm(input int d, input logic [3:0] a, input logic [3:0] be, input logic [31:0] v);
        if (int'(a) < dep(d)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[d][a][8*b +: 8] = v[8*b +: 8];
            end
        end
    endtask

    task automatic model_zero();
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 16; a++)
                mdl[d][a] = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access cycle on both ports; expected reads are taken from the
    // model before this cycle's writes are applied.
    task automatic step(input logic rd1, input logic wr1, input logic [3:0] a1,
                        input logic [3:0] be1, input logic [31:0] d1,
                        input logic rd2, input logic wr2, input logic [3:0] a2,
                        input logic [3:0] be2, input logic [31:0] d2, input logic clr);
        exp_t e;
        logic same;
        s1_chipselect = rd1 | wr1; s1_read = rd1; s1_write = wr1;
        s1_address = a1; s1_byteenable = be1; s1_writedata = d1;
        s2_chipselect = rd2 | wr2; s2_read = rd2; s2_write = wr2;
        s2_address = a2; s2_byteenable = be2; s2_writedata = d2;
        clear_req = clr;
        for (int d = 0; d < 3; d++) begin
            if (rd1 && !wr1) begin
                e.id = 2*d; e.data = rdm(d, a1); e.due = cyc + lat(d);
                sb.push_back(e);
            end
            if (rd2 && !wr2) begin
                e.id = 2*d + 1; e.data = rdm(d, a2); e.due = cyc + lat(d);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        same = wr1 && wr2 && (a1 == a2);
        for (int d = 0; d < 3; d++) begin
            if (wr2 && !same) wrm(d, a2, be2, d2);
            if (wr1) wrm(d, a1, be1, d1);
        end
        s1_chipselect = 0; s1_read = 0; s1_write = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0;
        clear_req = 0;
    endtask

    task automatic w1(input logic [3:0] a, input logic [31:0] v, input logic [3:0] be);
        step(0, 1, a, be, v, 0, 0, 4'd0, 4'd0, 32'h0, 0);
    endtask

    task automatic r2(input logic [3:0] a);
        step(0, 0, 4'd0, 4'd0, 32'h0, 1, 0, a, 4'd0, 32'h0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 4'd0, 32'h0, 0, 0, 4'd0, 4'd0, 32'h0, 0);
    endtask

    // Scoreboard: each readdatavalid pops the oldest entry for that port
    // and checks both the data and the cycle it arrived in.
    always @(negedge clk) begin
        if (!reset) begin
            for (int id = 0; id < 6; id++) begin
                if (rv[id]) begin
                    int k;
                    k = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (k < 0 && sb[i].id == id) k = i;
                    end
                    checks++;
                    assert (k >= 0) else begin
                        errors++;
                        $error("FAIL spurious_valid port %0d: observed valid 1 expected 0", id);
                    end
                    if (k >= 0) begin
                        chk($sformatf("rdata_port%0d", id), rd[id], sb[k].data);
                        chk($sformatf("latency_port%0d", id), 32'(cyc), 32'(sb[k].due));
                        sb.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; clear_req = 0;
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = 0; s1_byteenable = 0; s1_writedata = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = 0; s2_byteenable = 0; s2_writedata = 0;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_rdata1_%0d", d), rd[2*d], 32'h0);
            chk($sformatf("rst_rdata2_%0d", d), rd[2*d+1], 32'h0);
            chk($sformatf("rst_valid_%0d", d), {30'h0, rv[2*d+1], rv[2*d]}, 32'h0);
        end
        chk("rst_collision", col, 32'h0);
        chk("rst_busy", busy, 32'h7);
        chk("rst_wait", {wt2, wt1}, 32'h3f);

        repeat (2) @(posedge clk);
        @(negedge clk) reset = 0;
        for (int i = 0; i < 40 && busy != 0; i++) @(negedge clk);
        chk("init_sweep_done", busy, 32'h0);
        model_zero();

        // basic write then read-after-write, back-to-back reads
        w1(4'd5, 32'hDEADBEEF, 4'hF);
        r2(4'd5);
        for (int a = 0; a < 4; a++) r2(4'(a));
        r2(4'd5);
        idle(4);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("hold_valid_%0d", d), {31'h0, rv[2*d+1]}, 32'h0);
            chk($sformatf("hold_rdata_%0d", d), rd[2*d+1], 32'hDEADBEEF);
        end

        // byte enables with read-during-write across ports
        w1(4'd7, 32'h11223344, 4'hF);
        step(0, 1, 4'd7, 4'b0101, 32'hAABBCCDD, 1, 0, 4'd7, 4'd0, 32'h0, 0);
        r2(4'd7);
        idle(3);

        // collisions, then a dual write to distinct words
        step(0, 1, 4'd9, 4'hF, 32'h00000001, 0, 1, 4'd9, 4'hF, 32'h00000002, 0);
        chk("collision_pulse", col, 32'h7);
        r2(4'd9);
        chk("collision_end", col, 32'h0);
        w1(4'd9, 32'hFFFFFFFF, 4'hF);
        step(0, 1, 4'd9, 4'b0001, 32'h00000001, 0, 1, 4'd9, 4'hF, 32'h22222222, 0);
        chk("collision_pulse2", col, 32'h7);
        r2(4'd9);
        step(0, 1, 4'd10, 4'hF, 32'hA0A0A0A0, 0, 1, 4'd11, 4'hF, 32'hB1B1B1B1, 0);
        chk("no_collision", col, 32'h0);
        r2(4'd10);
        r2(4'd11);
        idle(3);

        // out of range on the DEPTH 12 instance
        w1(4'd13, 32'h00000055, 4'hF);
        for (int a = 0; a < 14; a++) r2(4'(a));
        idle(3);

        // clear sweep: fill, clear with a read in the request cycle, re-request mid-sweep
        for (int a = 0; a < 16; a++) w1(4'(a), 32'hFFFFFFFF, 4'hF);
        r2(4'd15);
        step(0, 0, 4'd0, 4'd0, 32'h0, 1, 0, 4'd2, 4'd0, 32'h0, 1);
        for (int i = 0; i < 18; i++) begin
            logic [2:0] eb;
            @(negedge clk);
            for (int d = 0; d < 3; d++) eb[d] = (i < dep(d));
            chk($sformatf("clr_busy_c%0d", i), busy, 32'(eb));
            chk($sformatf("clr_wait_c%0d", i), {wt2, wt1}, 32'({eb, eb}));
            clear_req = (i == 5);
        end
        clear_req = 0;
        model_zero();
        for (int a = 0; a < 16; a++) r2(4'(a));
        idle(3);

        // reset in the middle of a sweep
        w1(4'd3, 32'hCAFEF00D, 4'hF);
        w1(4'd15, 32'h12345678, 4'hF);
        r2(4'd3);
        idle(3);
        step(0, 0, 4'd0, 4'd0, 32'h0, 0, 0, 4'd0, 4'd0, 32'h0, 1);
        for (int i = 0; i <= 8; i++) @(negedge clk);
        reset = 1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_rdata_%0d", d), rd[2*d+1], 32'h0);
            chk($sformatf("midrst_valid_%0d", d), {30'h0, rv[2*d+1], rv[2*d]}, 32'h0);
        end
        chk("midrst_collision", col, 32'h0);
        chk("midrst_busy", busy, 32'h7);
        @(negedge clk) reset = 0;
        for (int j = 1; j <= 17; j++) begin
            logic [2:0] eb;
            @(negedge clk);
            for (int d = 0; d < 3; d++) eb[d] = (j < dep(d));
            chk($sformatf("resweep_busy_c%0d", j), busy, 32'(eb));
        end
        model_zero();
        r2(4'd3);
        r2(4'd15);

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle(1);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_tp_onchip_ram_dp.md
# config_tp_onchip_ram_dp

Parametrised true dual-port on-chip RAM for the Nios II system. It exposes two independent Avalon-MM slaves (s1, s2) on one clock and supports configurable width, depth and read latency. It adds port-A-priority write-collision resolution, out-of-range address handling and a built-in zeroization engine that clears the array after reset and on request. It replaces the fixed 32-bit × 8192 dual-port RAM as instruction/data memory shared between the CPU and a DMA master.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 13, word-address width
- DEPTH, 8192, number of words; DEPTH ≤ 2^ADDR_WIDTH
- READ_LATENCY, 1, 1 = unregistered output, 2 = extra output register
- CLEAR_ON_RESET, 1, 1 = run a clear sweep after every reset release
- clk  in  1  single system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- s1_address / s2_address  in  ADDR_WIDTH  word address
- s1_chipselect / s2_chipselect  in  1  port select
- s1_read / s2_read  in  1  read request
- s1_write / s2_write  in  1  write request
- s1_byteenable / s2_byteenable  in  DATA_WIDTH/8  per-byte write enable
- s1_writedata / s2_writedata  in  DATA_WIDTH  write data
- s1_readdata / s2_readdata  out  DATA_WIDTH  read data
- s1_readdatavalid / s2_readdatavalid  out  1  read data qualifier
- s1_waitrequest / s2_waitrequest  out  1  stall; high while the clear engine is busy
- clear_req  in  1  single-cycle request to zero the whole array
- clear_busy  out  1  clear sweep in progress
- collision  out  1  one-cycle pulse: same-address double write, port B dropped

## Operation
- Access accepted on port X in cycle N when X_chipselect & (X_read | X_write) & !X_waitrequest. Asserting read and write together is illegal; write takes precedence.
- Write: bytes with byteenable=1 are updated at the end of cycle N. Other bytes are unchanged.
- Read: returns array contents as of the start of cycle N, i.e. old data, including when the same or the other port writes that address in cycle N.
- Collision: both ports write the same address in the same cycle. Port A's write is committed and port B's is discarded entirely, including byte lanes A does not enable. collision pulses high in cycle N+1.
- Out-of-range (address ≥ DEPTH): writes are ignored. Reads return 0 with a normal readdatavalid.
- Clear FSM states:
  - IDLE: waitrequest=0. clear_req=1 moves to CLEAR next cycle with ptr=0.
  - CLEAR: writes all-zero to word ptr each cycle, ptr+1. At ptr=DEPTH-1 it writes, then returns to IDLE. clear_req is ignored while in CLEAR.
- During reset the FSM enters CLEAR with ptr=0 if CLEAR_ON_RESET=1, else IDLE.
- Reset mid-sweep restarts the sweep from 0 (CLEAR_ON_RESET=1) or abandons it (=0). Array contents are never reset directly.
- Read pipeline entries accepted before the clear sweep starts complete normally with readdatavalid.

## Timing
- Reset values: readdata 0, readdatavalid 0, collision 0, clear_busy = waitrequest = CLEAR_ON_RESET.
- Read latency: readdatavalid and readdata are valid in cycle N+READ_LATENCY. Fully pipelined, one read per port per cycle, no bubbles. readdata holds its value when readdatavalid=0.
- Write latency 0: a read accepted in cycle N+1 sees data written in cycle N.
- clear_busy and waitrequest are registered FSM decodes:
  - If clear_req is high in IDLE cycle N, accesses in cycle N are still accepted. Waitrequest rises in N+1.
  - The sweep lasts exactly DEPTH cycles. Waitrequest falls in the cycle after ptr=DEPTH-1 is written.
- After reset release with CLEAR_ON_RESET=1, word k is zeroed in cycle k, counting from the first edge after release.

## Test plan
- Basic access, READ_LATENCY=1 then 2: s1 writes 0xDEADBEEF to addr 5, s2 reads addr 5 the next cycle -> s2_readdata=0xDEADBEEF with readdatavalid exactly 1 (resp. 2) cycles after acceptance. Back-to-back reads to addrs 0..3 return in order with no gaps.
- Byte enables and mixed-port read-during-write: preload 0x11223344 at addr 7. s1 writes 0xAABBCCDD with byteenable 0101 while s2 reads addr 7 -> s2 returns 0x11223344. A following read returns 0x11BB33DD.
- Collision: both ports write addr 9 in the same cycle (A=0x1, B=0x2, B byteenable 1111) -> collision high for one cycle, addr 9 reads 0x00000001.
- Clear: DEPTH=16, fill all words with 0xFFFFFFFF, pulse clear_req -> waitrequest high for exactly 16 cycles starting the next cycle. All 16 words then read 0. A second clear_req during the sweep has no effect.
- Reset mid-sweep (CLEAR_ON_RESET=1): assert reset at ptr=8 -> all outputs take reset values immediately. After release, the sweep restarts at 0 and lasts DEPTH cycles.
- Out-of-range: DEPTH=12, ADDR_WIDTH=4. Write 0x55 to addr 13, then read addr 13 -> readdata 0. Words 0..11 are unchanged.
